// File: rtl/rotator_multiplier.sv
// ---------------------------------------------------------------------------
// rotator_multiplier
//
// Pipelined complex multiplier placed directly after the twiddle (rotator)
// memory of the FFT datapath. Every cycle it may accept one complex sample
// together with its Q1.16 rotator and produces the rounded, rescaled and
// saturated complex product three cycles later. It also tags the last
// sample of every frame of N consecutive valid samples.
//
// Pipeline:
//   stage 1 : register sample, rotator, valid, and the frame "last" tag
//   stage 2 : register the four partial products
//   stage 3 : sum, round half up, shift by FRAC, saturate, register outputs
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   synchronous active-high reset
//   data_valid    in   sample and rotator are presented this cycle
//   data_real     in   [DW-1:0] signed sample real part
//   data_img      in   [DW-1:0] signed sample imaginary part
//   rotator_real  in   [RW-1:0] signed Q1.16 rotator real part
//   rotator_img   in   [RW-1:0] signed Q1.16 rotator imaginary part
//   out_valid     out  product valid
//   out_real      out  [DW-1:0] signed product real part
//   out_img       out  [DW-1:0] signed product imaginary part
//   out_last      out  high with the N-th valid output of a frame
//   out_sat       out  real and/or imaginary part was saturated
// ---------------------------------------------------------------------------
module rotator_multiplier #(
  parameter int DW   = 16,
  parameter int RW   = 18,
  parameter int FRAC = 16,
  parameter int N    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          data_valid,
  input  logic [DW-1:0] data_real,
  input  logic [DW-1:0] data_img,
  input  logic [RW-1:0] rotator_real,
  input  logic [RW-1:0] rotator_img,
  output logic          out_valid,
  output logic [DW-1:0] out_real,
  output logic [DW-1:0] out_img,
  output logic          out_last,
  output logic          out_sat
);

  // Counter width; a frame of one sample still needs a 1-bit counter.
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  // Product width and sum width (one extra bit so the sum cannot overflow).
  localparam int PW = DW + RW;
  localparam int SW = PW + 1;

  localparam logic [CW-1:0]        CNT_LAST = CW'(N - 1);
  localparam logic signed [SW-1:0] HALF     = SW'(2 ** (FRAC - 1));
  localparam logic signed [SW-1:0] MAX_OUT  = SW'(2 ** (DW - 1) - 1);
  localparam logic signed [SW-1:0] MIN_OUT  = SW'(-(2 ** (DW - 1)));

  // ------------------------------------------------------------------------
  // Stage 1 state
  // ------------------------------------------------------------------------
  logic [CW-1:0]        cnt;
  logic                 s1_valid;
  logic                 s1_last;
  logic signed [DW-1:0] s1_dr;
  logic signed [DW-1:0] s1_di;
  logic signed [RW-1:0] s1_rr;
  logic signed [RW-1:0] s1_ri;

  // ------------------------------------------------------------------------
  // Stage 2 state
  // ------------------------------------------------------------------------
  logic                 s2_valid;
  logic                 s2_last;
  logic signed [PW-1:0] s2_rr;
  logic signed [PW-1:0] s2_ii;
  logic signed [PW-1:0] s2_ri;
  logic signed [PW-1:0] s2_ir;

  // ------------------------------------------------------------------------
  // Combinational products and stage-3 arithmetic
  // ------------------------------------------------------------------------
  logic signed [PW-1:0] prod_rr;
  logic signed [PW-1:0] prod_ii;
  logic signed [PW-1:0] prod_ri;
  logic signed [PW-1:0] prod_ir;

  logic signed [SW-1:0] sum_re;
  logic signed [SW-1:0] sum_im;
  logic signed [SW-1:0] scaled_re;
  logic signed [SW-1:0] scaled_im;
  logic signed [DW-1:0] clip_re;
  logic signed [DW-1:0] clip_im;
  logic                 sat_re;
  logic                 sat_im;

  // Stage 1: capture the sample and rotator, and derive the frame tag.
  // The frame counter restarts whenever data_valid drops, so a gap aborts
  // a partial frame exactly like the rotator memory's own address counter.
  // The data registers only load on valid cycles and otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_dr    <= '0;
      s1_di    <= '0;
      s1_rr    <= '0;
      s1_ri    <= '0;
    end else begin
      s1_valid <= data_valid;
      s1_last  <= data_valid && (cnt == CNT_LAST);
      if (data_valid) begin
        cnt   <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
        s1_dr <= data_real;
        s1_di <= data_img;
        s1_rr <= rotator_real;
        s1_ri <= rotator_img;
      end else begin
        cnt <= '0;
      end
    end
  end

  // The four partial products. Operands are sign-extended to the full
  // product width first so the multiply is done at DW+RW bits.
  assign prod_rr = PW'(s1_dr) * PW'(s1_rr);
  assign prod_ii = PW'(s1_di) * PW'(s1_ri);
  assign prod_ri = PW'(s1_dr) * PW'(s1_ri);
  assign prod_ir = PW'(s1_di) * PW'(s1_rr);

  // Stage 2: register the partial products alongside valid and last.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_rr    <= '0;
      s2_ii    <= '0;
      s2_ri    <= '0;
      s2_ir    <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      if (s1_valid) begin
        s2_rr <= prod_rr;
        s2_ii <= prod_ii;
        s2_ri <= prod_ri;
        s2_ir <= prod_ir;
      end
    end
  end

  // Complex sums, then round half up: adding half an LSB before the
  // arithmetic shift turns the floor of the shift into round-half-up.
  always_comb begin
    sum_re    = SW'(s2_rr) - SW'(s2_ii);
    sum_im    = SW'(s2_ri) + SW'(s2_ir);
    scaled_re = (sum_re + HALF) >>> FRAC;
    scaled_im = (sum_im + HALF) >>> FRAC;
  end

  // Clamp each part to the signed DW range and flag when clamping happened.
  // Only -1.0 * -1.0 style corner cases and large-magnitude rotations can
  // exceed the range, since |rotator| is nominally at most 1.0.
  always_comb begin
    sat_re  = 1'b0;
    sat_im  = 1'b0;
    clip_re = scaled_re[DW-1:0];
    clip_im = scaled_im[DW-1:0];
    if (scaled_re > MAX_OUT) begin
      clip_re = MAX_OUT[DW-1:0];
      sat_re  = 1'b1;
    end else if (scaled_re < MIN_OUT) begin
      clip_re = MIN_OUT[DW-1:0];
      sat_re  = 1'b1;
    end
    if (scaled_im > MAX_OUT) begin
      clip_im = MAX_OUT[DW-1:0];
      sat_im  = 1'b1;
    end else if (scaled_im < MIN_OUT) begin
      clip_im = MIN_OUT[DW-1:0];
      sat_im  = 1'b1;
    end
  end

  // Stage 3: output registers. The status bits are gated by the stage valid
  // so they can never be seen high while out_valid is low; the data fields
  // hold their last value across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_sat   <= 1'b0;
      out_real  <= '0;
      out_img   <= '0;
    end else begin
      out_valid <= s2_valid;
      out_last  <= s2_valid && s2_last;
      out_sat   <= s2_valid && (sat_re || sat_im);
      if (s2_valid) begin
        out_real <= clip_re;
        out_img  <= clip_im;
      end
    end
  end

endmodule

// File: tb/tb_rotator_multiplier.sv
// ---------------------------------------------------------------------------
// tb_rotator_multiplier
//
// Directed bench for rotator_multiplier. A behavioural model predicts, from
// each sampled input, the complex product and frame tag that must appear
// three cycles later; a compare process checks the DUT every cycle. Literal
// hand-computed results pin both the DUT and the model.
// ---------------------------------------------------------------------------
module tb_rotator_multiplier;

  localparam int DW   = 16;
  localparam int RW   = 18;
  localparam int FRAC = 16;
  localparam int N    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          data_valid = 1'b0;
  logic [DW-1:0] data_real = '0;
  logic [DW-1:0] data_img = '0;
  logic [RW-1:0] rotator_real = '0;
  logic [RW-1:0] rotator_img = '0;
  logic          out_valid;
  logic [DW-1:0] out_real;
  logic [DW-1:0] out_img;
  logic          out_last;
  logic          out_sat;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int run_len = 0;
  int last_seen = 0;

  // Expected output visible after edge E lives in slot E % 8.
  bit     exp_v[8];
  bit     exp_last[8];
  bit     exp_sat[8];
  longint exp_re[8];
  longint exp_im[8];

  int rot_tab_re[8] = '{65536, 46341, 0, -46341, -65536, -46341, 0, 46341};
  int rot_tab_im[8] = '{0, -46341, -65536, -46341, 0, 46341, 65536, 46341};

  rotator_multiplier #(.DW(DW), .RW(RW), .FRAC(FRAC), .N(N)) dut (
    .clk(clk),
    .rst(rst),
    .data_valid(data_valid),
    .data_real(data_real),
    .data_img(data_img),
    .rotator_real(rotator_real),
    .rotator_img(rotator_img),
    .out_valid(out_valid),
    .out_real(out_real),
    .out_img(out_img),
    .out_last(out_last),
    .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  // Complex product, rounded half up, scaled and clamped, in plain integers.
  function automatic void model(input longint dr, input longint di,
                                input longint rr, input longint ri,
                                output longint re, output longint im,
                                output bit sat);
    longint lo;
    longint hi;
    longint full_re;
    longint full_im;
    lo = -(64'sd1 <<< (DW - 1));
    hi = (64'sd1 <<< (DW - 1)) - 1;
    full_re = dr * rr - di * ri;
    full_im = dr * ri + di * rr;
    re = (full_re + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
    im = (full_im + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
    sat = 1'b0;
    if (re > hi) begin re = hi; sat = 1'b1; end
    if (re < lo) begin re = lo; sat = 1'b1; end
    if (im > hi) begin im = hi; sat = 1'b1; end
    if (im < lo) begin im = lo; sat = 1'b1; end
  endfunction

  function automatic void cmp(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d (edge %0d)", name, act, req, edge_n);
    end
  endfunction

  // Model: sample inputs on each rising edge and schedule the result two
  // edges later. Reset discards everything in flight and restarts framing.
  always @(posedge clk) begin
    longint r;
    longint i;
    bit     s;
    int     slot;
    edge_n++;
    slot = (edge_n + 2) % 8;
    if (rst) begin
      for (int k = 0; k < 8; k++) exp_v[k] = 1'b0;
      run_len = 0;
    end else begin
      exp_v[slot]    = data_valid;
      exp_last[slot] = 1'b0;
      exp_sat[slot]  = 1'b0;
      if (data_valid) begin
        run_len++;
        model(longint'($signed(data_real)), longint'($signed(data_img)),
              longint'($signed(rotator_real)), longint'($signed(rotator_img)),
              r, i, s);
        exp_re[slot]   = r;
        exp_im[slot]   = i;
        exp_sat[slot]  = s;
        exp_last[slot] = (run_len % N) == 0;
      end else begin
        run_len = 0;
      end
    end
  end

  // Compare the DUT against the model on every falling edge.
  always @(negedge clk) begin
    int slot;
    if (edge_n >= 1) begin
      slot = edge_n % 8;
      if (exp_v[slot]) begin
        cmp("out_valid", longint'(out_valid), 1);
        cmp("out_real", longint'($signed(out_real)), exp_re[slot]);
        cmp("out_img", longint'($signed(out_img)), exp_im[slot]);
        cmp("out_last", longint'(out_last), longint'(exp_last[slot]));
        cmp("out_sat", longint'(out_sat), longint'(exp_sat[slot]));
        if (out_valid && out_last) last_seen++;
      end else begin
        cmp("idle_valid", longint'(out_valid), 0);
        cmp("idle_last", longint'(out_last), 0);
        cmp("idle_sat", longint'(out_sat), 0);
      end
    end
  end

  task automatic applyStimulus(input bit v, input int dr, input int di,
                               input int rr, input int ri);
    data_valid   = v;
    data_real    = DW'(dr);
    data_img     = DW'(di);
    rotator_real = RW'(rr);
    rotator_img  = RW'(ri);
    @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    for (int k = 0; k < cycles; k++) applyStimulus(1'b0, 0, 0, 0, 0);
  endtask

  // Literal check of the output that belongs to the sample applied
  // exactly three cycles ago.
  task automatic checkOutput(input string name, input int re, input int im,
                             input bit sat, input bit last);
    cmp({name, "_valid"}, longint'(out_valid), 1);
    cmp({name, "_re"}, longint'($signed(out_real)), longint'(re));
    cmp({name, "_im"}, longint'($signed(out_img)), longint'(im));
    cmp({name, "_sat"}, longint'(out_sat), longint'(sat));
    cmp({name, "_last"}, longint'(out_last), longint'(last));
  endtask

  task automatic directed(input string name, input int dr, input int di,
                          input int rr, input int ri, input int re,
                          input int im, input bit sat);
    applyStimulus(1'b1, dr, di, rr, ri);
    idle(2);
    checkOutput(name, re, im, sat, 1'b0);
    idle(1);
  endtask

  initial begin
    longint r;
    longint i;
    bit     s;

    // Model pins against hand-worked products.
    model(1000, 0, 46341, -46341, r, i, s);
    cmp("model_w1_re", r, 707);
    cmp("model_w1_im", i, -707);
    model(32767, 32767, 46341, -46341, r, i, s);
    cmp("model_sat_re", r, 32767);
    cmp("model_sat_flag", longint'(s), 1);

    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cmp("reset_valid", longint'(out_valid), 0);
    cmp("reset_real", longint'($signed(out_real)), 0);
    cmp("reset_img", longint'($signed(out_img)), 0);
    cmp("reset_last", longint'(out_last), 0);
    cmp("reset_sat", longint'(out_sat), 0);
    rst = 1'b0;
    idle(2);

    directed("identity", 1234, -567, 65536, 0, 1234, -567, 1'b0);
    directed("w1", 1000, 0, 46341, -46341, 707, -707, 1'b0);
    directed("w2", 100, 200, 0, -65536, 200, -100, 1'b0);
    directed("sat", 32767, 32767, 46341, -46341, 32767, 0, 1'b1);
    directed("ident_min", -32768, -32768, 65536, 0, -32768, -32768, 1'b0);
    directed("neg_min", -32768, 0, -65536, 0, 32767, 0, 1'b1);
    idle(2);

    // Sixteen back-to-back samples: two complete frames.
    last_seen = 0;
    for (int k = 0; k < 16; k++)
      applyStimulus(1'b1, int'($urandom_range(0, 65535)) - 32768,
                    int'($urandom_range(0, 65535)) - 32768,
                    rot_tab_re[k % 8], rot_tab_im[k % 8]);
    idle(4);
    cmp("frame16_lasts", longint'(last_seen), 2);

    // Partial frame aborted by a one-cycle gap, then a full frame.
    last_seen = 0;
    for (int k = 0; k < 5; k++)
      applyStimulus(1'b1, 300 * k - 700, 1000 - 250 * k, rot_tab_re[k], rot_tab_im[k]);
    idle(1);
    for (int k = 0; k < 8; k++)
      applyStimulus(1'b1, 4000 - 900 * k, 111 * k, rot_tab_re[k], rot_tab_im[k]);
    idle(4);
    cmp("gap_lasts", longint'(last_seen), 1);

    // Reset while samples are in flight; the sample on the reset edge is
    // dropped as well.
    applyStimulus(1'b1, 5000, -5000, 65536, 0);
    applyStimulus(1'b1, 6000, 7000, 46341, 46341);
    rst = 1'b1;
    applyStimulus(1'b1, 7000, 1, 0, 65536);
    rst = 1'b0;
    cmp("rst_mid_valid", longint'(out_valid), 0);
    cmp("rst_mid_real", longint'($signed(out_real)), 0);
    cmp("rst_mid_img", longint'($signed(out_img)), 0);
    cmp("rst_mid_last", longint'(out_last), 0);
    cmp("rst_mid_sat", longint'(out_sat), 0);
    idle(4);
    last_seen = 0;
    for (int k = 0; k < 8; k++)
      applyStimulus(1'b1, 2000 + 17 * k, -3000 + 29 * k, rot_tab_re[k], rot_tab_im[k]);
    idle(4);
    cmp("post_rst_lasts", longint'(last_seen), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rotator_multiplier.md
# rotator_multiplier

Pipelined complex multiplier that sits directly downstream of the 8-point twiddle (rotator) memory in the FFT datapath. Each cycle it accepts one complex data sample together with the 18-bit Q1.16 rotator value presented alongside it, and forms the product. It rescales the product back to the data width with round-half-up and saturation. It also tags the last sample of each frame of `N` consecutive valid samples.

## Interface
Parameters:
- `DW`, 16: signed width of data input and output real/imaginary parts.
- `RW`, 18: signed rotator width. Format is Q1.16, so 65536 = +1.0 and 46341 = cos45.
- `FRAC`, 16: fractional bits of the rotator. This is also the product right-shift.
- `N`, 8: frame length in samples. Must be a power of two.

Ports:
- `clk`  in  1  clock. All logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `data_valid`  in  1  a sample and its rotator are presented this cycle.
- `data_real`  in  DW  signed real part of the sample.
- `data_img`  in  DW  signed imaginary part of the sample.
- `rotator_real`  in  RW  signed rotator real part. Upstream aligns it to `data_valid`.
- `rotator_img`  in  RW  signed rotator imaginary part.
- `out_valid`  out  1  product valid.
- `out_real`  out  DW  signed product real part.
- `out_img`  out  DW  signed product imaginary part.
- `out_last`  out  1  asserted with the N-th valid output of a frame.
- `out_sat`  out  1  real and/or imaginary part of this output was saturated.

## Operation
- There is no backpressure. Every input cycle with `data_valid` high produces exactly one output cycle with `out_valid` high, exactly 3 cycles later. Samples keep their order.
- Stage 1 registers the inputs and the valid bit. It also computes the last tag from a frame counter `cnt` (log2(N) bits):
  - When `data_valid` is high: tag = (`cnt` == N-1), and `cnt` <= `cnt`+1, wrapping N-1 -> 0.
  - When `data_valid` is low: `cnt` <= 0, so a gap aborts a partial frame. This matches the rotator memory's counter reset on a valid drop.
- Stage 2 registers the four signed products dr*rr, di*ri, dr*ri, di*rr. Each is DW+RW bits.
- Stage 3 forms the sums, rounds, scales and saturates:
  - Sums at DW+RW+1 bits: re = dr*rr - di*ri, im = dr*ri + di*rr.
  - Round half up: add 2^(FRAC-1), then arithmetic shift right by FRAC.
  - Saturate to [-2^(DW-1), 2^(DW-1)-1].
  - `out_sat` = saturation occurred on either part.
- Valid, last and all data fields travel as one pipeline, in lock-step.
- When a stage is not valid, its data registers hold their previous value; only the valid/last/sat bits are meaningful.
- `out_last`, `out_sat` and `out_valid` are never high while `out_valid` is low. `out_last` and `out_sat` are qualified by `out_valid`.

## Timing
- Reset values: `out_valid` = 0, `out_last` = 0, `out_sat` = 0, `out_real` = 0, `out_img` = 0, `cnt` = 0. All internal pipeline valid bits are 0.
- Latency: input in cycle t -> output in cycle t+3. Throughput is one sample per cycle.
- Reset mid-operation: on the first edge with `rst` high, all in-flight samples are discarded and `cnt` is cleared.
  - No `out_valid` is produced from samples accepted before reset.
  - The first input after `rst` falls starts a new frame at `cnt` = 0.
- `rst` and `data_valid` high on the same edge: reset wins and the sample is dropped.
- Frame wrap: valid inputs 0..N-1 back-to-back give `out_last` only on the N-th output. Input N starts the next frame with no bubble.
- Rotator +1.0 (65536, 0): output equals input exactly, with no rounding error and no saturation, except that -2^(DW-1) is passed through unchanged.

## Test plan
- Identity: rotator (65536, 0), data (1234, -567) valid for one cycle -> 3 cycles later `out_valid` = 1, output (1234, -567), `out_sat` = 0, `out_last` = 0. All other cycles have `out_valid` = 0.
- W1 rounding: data (1000, 0), rotator (46341, -46341) -> output (707, -707).
- W2: data (100, 200), rotator (0, -65536) -> output (200, -100).
- Saturation: data (32767, 32767), rotator (46341, -46341) -> output (32767, 0), `out_sat` = 1.
- Frame tagging:
  - 16 back-to-back valid samples -> `out_last` on outputs 8 and 16 only.
  - Then 5 valid samples, a 1-cycle gap, then 8 valid samples -> `out_last` only on the 8th sample after the gap.
- Reset mid-stream: assert `rst` for 1 cycle while 3 samples are in flight -> no `out_valid` from them. All outputs read 0 on the cycle after reset. The next 8 valid inputs give `out_last` on the 8th.
